nearest_point: RTL

NEAREST_POINT -- requirements
Module: nearest_point

---
 rtl/nearest_point_pkg.sv | 21 ++
 rtl/nearest_point_tag_pipe.sv | 37 +++
 rtl/nearest_point.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/nearest_point_pkg.sv
// Shared types and widths for the nearest-point search engine.
package nearest_point_pkg;

  localparam int unsigned COORD_W = 8;
  localparam int unsigned DIST_W  = 32;

  localparam logic [DIST_W-1:0] DIST_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } point_t;

endpackage

// File: rtl/nearest_point_tag_pipe.sv
// Shift pipe that follows each launched operand pair through the external
// distance unit, so the returning result can be matched to its table index.
module tag_pipe #(
  parameter int unsigned depth = 6,
  parameter int unsigned width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [width-1:0] din,
  output logic             live,
  output logic [width-1:0] dout,
  output logic             empty_c
);

  logic [depth-1:0] live_q;
  logic [width-1:0] data_q [depth];

  always_ff @(posedge clk) begin
    if (rst) begin
      live_q <= '0;
      for (int unsigned i = 0; i < depth; i++) data_q[i] <= '0;
    end else begin
      live_q[0] <= push;
      data_q[0] <= din;
      for (int unsigned i = 1; i < depth; i++) begin
        live_q[i] <= live_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign live    = live_q[depth-1];
  assign dout    = data_q[depth-1];
  assign empty_c = ~|live_q;

endmodule

// File: rtl/nearest_point.sv
// Nearest-point search: streams every table entry to an external distance
// unit and keeps the smallest returned distance among valid entries.
module nearest_point
  import nearest_point_pkg::*;
#(
  parameter int unsigned N   = 8,
  parameter int unsigned LAT = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(N)-1:0]       wr_addr,
  input  logic [COORD_W-1:0]         wr_x,
  input  logic [COORD_W-1:0]         wr_y,
  input  logic                       start,
  input  logic [COORD_W-1:0]         qx,
  input  logic [COORD_W-1:0]         qy,
  output logic [COORD_W-1:0]         dx1,
  output logic [COORD_W-1:0]         dy1,
  output logic [COORD_W-1:0]         dx2,
  output logic [COORD_W-1:0]         dy2,
  input  logic [DIST_W-1:0]          dist_in,
  output logic                       busy,
  output logic                       done,
  output logic                       found,
  output logic [$clog2(N)-1:0]       best_idx,
  output logic [DIST_W-1:0]          best_dist
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned TW = IW + 1;

  point_t          tab [N];
  logic [N-1:0]    tab_valid;
  logic            wr_ok_c;

  state_t          state, state_next;
  logic [IW-1:0]   cnt;
  point_t          q_r;
  logic            accept_c, launch_c, finish_c;

  logic [TW-1:0]   tag_in, tag_out;
  logic            tag_live, tag_empty_c;

  logic [DIST_W-1:0] run_dist;
  logic [IW-1:0]     run_idx;
  logic              run_found;

  // Writes are refused for the whole search so the table is stable per query.
  assign wr_ok_c = wr_en && !busy;

  always_ff @(posedge clk) begin
    if (wr_ok_c) tab[wr_addr] <= {wr_x, wr_y};
  end

  always_ff @(posedge clk) begin
    if (rst) tab_valid <= '0;
    else if (wr_ok_c) tab_valid[wr_addr] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    launch_c   = 1'b0;
    finish_c   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept_c   = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        launch_c = 1'b1;
        if (cnt == IW'(N - 1)) state_next = DRAIN;
      end
      DRAIN: begin
        if (tag_empty_c) begin
          finish_c   = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign tag_in = {tab_valid[cnt], cnt};

  tag_pipe #(
    .depth (LAT + 1),
    .width (TW)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .push    (launch_c),
    .din     (tag_in),
    .live    (tag_live),
    .dout    (tag_out),
    .empty_c (tag_empty_c)
  );

  // Launch, result tracking and result publication.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      q_r       <= '0;
      dx1       <= '0;
      dy1       <= '0;
      dx2       <= '0;
      dy2       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      found     <= 1'b0;
      best_idx  <= '0;
      best_dist <= '0;
      run_dist  <= DIST_MAX;
      run_idx   <= '0;
      run_found <= 1'b0;
    end else begin
      done <= finish_c;
      if (accept_c) begin
        q_r       <= {qx, qy};
        busy      <= 1'b1;
        cnt       <= '0;
        run_dist  <= DIST_MAX;
        run_idx   <= '0;
        run_found <= 1'b0;
      end else if (tag_live && tag_out[IW]) begin
        run_found <= 1'b1;
        // Strict compare: on a tie the earlier, lower index is kept.
        if (dist_in < run_dist) begin
          run_dist <= dist_in;
          run_idx  <= tag_out[IW-1:0];
        end
      end
      if (launch_c) begin
        dx1 <= q_r.x;
        dy1 <= q_r.y;
        dx2 <= tab[cnt].x;
        dy2 <= tab[cnt].y;
        cnt <= cnt + IW'(1);
      end
      if (finish_c) begin
        busy      <= 1'b0;
        found     <= run_found;
        best_idx  <= run_idx;
        best_dist <= run_dist;
      end
    end
  end

endmodule
